time_dmr_mode_ctrl: RTL and testbench
=====================================

Name: time_dmr_mode_ctrl

Overview:
- Mode and health controller for the retry_start -> time_DMR_start -> time_DMR_end -> retry_end chain.
- Owns the enable_i of both time-DMR stages. Switches redundancy on or off only after draining in-flight transactions, with upstream issue stalled during the drain.
- Counts detected faults, tracks consecutive retries per ID, and flags IDs that exhaust their retry budget.
- Sits beside the datapath and observes handshakes only; it carries no data.

Parameters:
- ID_SIZE, 4: width of the transaction ID; 2**ID_SIZE IDs.
- MaxRetries, 3: consecutive faulty detections of one ID that count as exhaustion; must be >= 1.
- DrainTimeout, 64: cycles allowed in a drain state before the switch is forced; must be >= 1.
- FaultCntWidth, 16: width of the fault counter.
- EnableDefault, 0: value of enable_o after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_req_i  in  1  requested redundancy mode (level).
- issue_valid_i  in  1  valid at the upstream input of retry_start.
- issue_ready_i  in  1  ready at the upstream input of retry_start.
- complete_valid_i  in  1  valid at the downstream output of retry_end.
- complete_ready_i  in  1  ready at the downstream output of retry_end.
- detect_valid_i  in  1  valid at the time_DMR_end output.
- detect_ready_i  in  1  ready at the time_DMR_end output.
- detect_faulty_i  in  1  faulty_o of time_DMR_end.
- detect_id_i  in  ID_SIZE  id_o of time_DMR_end.
- clear_i  in  1  synchronous clear of counters and sticky flags.
- enable_o  out  1  drives enable_i of time_DMR_start and time_DMR_end.
- stall_o  out  1  integrator ANDs ~stall_o into the upstream valid and ready.
- busy_o  out  1  high while in a drain state.
- inflight_o  out  ID_SIZE+1  transactions issued but not yet completed.
- fault_cnt_o  out  FaultCntWidth  saturating count of faulty detections.
- exhausted_o  out  1  one-cycle pulse when an ID hits MaxRetries.
- exhausted_id_o  out  ID_SIZE  ID that caused the last exhaustion; holds its value.
- drain_timeout_o  out  1  sticky: a drain was forced by timeout.
- overflow_o  out  1  sticky: issue accepted while inflight == 2**ID_SIZE.

Behaviour:
- Reset values:
  - enable_o = EnableDefault.
  - stall_o, busy_o, exhausted_o, drain_timeout_o, overflow_o = 0.
  - All counters = 0; exhausted_id_o = 0.
  - FSM enters STEADY.
- Event definitions:
  - issue = issue_valid_i & issue_ready_i & ~stall_o.
  - complete = complete_valid_i & complete_ready_i.
  - detect = detect_valid_i & detect_ready_i.
- Inflight counter:
  - +1 on issue, -1 on complete; both in the same cycle means no change.
  - Retries never touch the counter: they re-enter inside retry_start and only the fault-free copy completes.
  - Issue at 2**ID_SIZE: counter holds and overflow_o sets.
  - Complete at 0: counter holds at 0.
- FSM states: STEADY, DRAIN, SWITCH.
  - STEADY -> DRAIN when enable_req_i != enable_o and no stalled handshake is pending (not (issue_valid_i & ~issue_ready_i)). A pending handshake defers the transition.
  - DRAIN: stall_o = 1 and busy_o = 1, both registered, so they are high from the first DRAIN cycle. The timeout counter increments every cycle.
  - DRAIN -> STEADY when enable_req_i == enable_o again (drain aborted); stall_o drops the next cycle.
  - DRAIN -> SWITCH when inflight_o == 0, or when the timeout counter reaches DrainTimeout-1. The timeout case sets drain_timeout_o.
  - SWITCH (one cycle): enable_o <= ~enable_o, the timeout counter clears, per-ID retry counters clear, then -> STEADY. stall_o stays 1 during SWITCH and is 0 from the STEADY cycle after.
  - Request and completion arriving in the same cycle in DRAIN: completion wins, go to SWITCH.
- Retry tracking: one counter per ID, width $clog2(MaxRetries+1).
  - On detect & detect_faulty_i: fault_cnt_o increments and saturates at all-ones. The counter of detect_id_i increments.
  - If that counter reaches MaxRetries: exhausted_o pulses the next cycle, exhausted_id_o loads the ID, and the counter clears.
  - On detect & ~detect_faulty_i: the counter of detect_id_i clears.
  - Detection tracking is active only while enable_o = 1; detects are ignored while disabled.
- clear_i:
  - Zeroes fault_cnt_o, the per-ID counters, drain_timeout_o and overflow_o.
  - Does not affect the FSM, enable_o or inflight_o.
  - If clear_i and a faulty detect occur in the same cycle, clear wins.
- Asynchronous reset mid-drain: the FSM returns to STEADY with enable_o = EnableDefault.
- Latency:
  - Mode change takes at least 2 cycles from request (DRAIN + SWITCH).
  - All outputs are registered.

Decomposition:
- Package time_dmr_ctrl_pkg:
  - state enum (STEADY, DRAIN, SWITCH).
  - helper function for the retry-counter width.
- Sub-module retry_budget_tracker: the per-ID counter array plus the exhaustion pulse and ID. It is instantiated once.

Test Plan:
- Idle enable: EnableDefault=0, inflight 0, enable_req_i 0->1 -> DRAIN 1 cycle, SWITCH 1 cycle, enable_o=1 at cycle 2; stall_o high for exactly 2 cycles.
- Drain wait: 3 issued, none completed, then request toggles -> stall_o holds; enable_o flips 1 cycle after the 3rd completion; inflight_o goes 3,2,1,0.
- Timeout: DrainTimeout=8, 1 transaction stuck -> SWITCH after 8 DRAIN cycles; drain_timeout_o=1 and stays set until clear_i.
- Abort: request toggles, then toggles back 2 cycles later with inflight>0 -> return to STEADY; enable_o unchanged; stall_o low the next cycle.
- Exhaustion: MaxRetries=3, ID 5 faulty three times consecutively -> exhausted_o one pulse, exhausted_id_o=5, fault_cnt_o=3. Sequence faulty, clean, faulty, faulty on ID 5 -> no pulse.
- Simultaneous events: issue and complete in the same cycle at inflight=2 -> stays 2. Issue at inflight=16 with ID_SIZE=4 -> overflow_o=1, count holds at 16.

Source files
------------

// File: rtl/time_dmr_ctrl_pkg.sv
// Shared types and helpers for the time-DMR mode and health controller.
package time_dmr_ctrl_pkg;

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } ctrl_state_e;

    // Width of a per-ID retry counter able to hold 0..max_retries.
    function automatic int retry_cnt_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/retry_budget_tracker.sv
// Per-ID consecutive-fault counters; flags the ID that exhausts its retry budget.
module retry_budget_tracker
    import time_dmr_ctrl_pkg::*;
#(
    parameter int ID_SIZE    = 4,
    parameter int MaxRetries = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               track_en,
    input  logic               faulty,
    input  logic [ID_SIZE-1:0] id,
    input  logic               clear,
    output logic               exhausted,
    output logic [ID_SIZE-1:0] exhausted_id
);

    localparam int NumIds = 2 ** ID_SIZE;
    localparam int CntW   = retry_cnt_width(MaxRetries);
    localparam logic [CntW-1:0] CntLimit = CntW'(MaxRetries);

    logic [NumIds-1:0][CntW-1:0] cnt_reg;
    logic [NumIds-1:0][CntW-1:0] cnt_next;
    logic                        hit;
    logic                        exhausted_reg;
    logic [ID_SIZE-1:0]          exhausted_id_reg;

    // Clear takes priority over a same-cycle faulty detection.
    assign hit = track_en & faulty & ~clear & ((cnt_reg[id] + CntW'(1)) == CntLimit);

    for (genvar gi = 0; gi < NumIds; gi++) begin : g_cnt
        assign cnt_next[gi] = clear ? '0 :
                              (track_en && (id == ID_SIZE'(gi))) ?
                                  ((faulty && !hit) ? (cnt_reg[gi] + CntW'(1)) : '0) :
                              cnt_reg[gi];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg          <= '0;
            exhausted_reg    <= 1'b0;
            exhausted_id_reg <= '0;
        end else begin
            cnt_reg       <= cnt_next;
            exhausted_reg <= hit;
            if (hit) begin
                exhausted_id_reg <= id;
            end
        end
    end

    assign exhausted    = exhausted_reg;
    assign exhausted_id = exhausted_id_reg;

endmodule

// File: rtl/time_dmr_mode_ctrl.sv
// Mode/health controller for the retry + time-DMR chain: drains in-flight work
// before toggling redundancy, and tracks fault and retry health.
module time_dmr_mode_ctrl
    import time_dmr_ctrl_pkg::*;
#(
    parameter int ID_SIZE       = 4,
    parameter int MaxRetries    = 3,
    parameter int DrainTimeout  = 64,
    parameter int FaultCntWidth = 16,
    parameter bit EnableDefault = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_req_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_ready_i,
    input  logic                     complete_valid_i,
    input  logic                     complete_ready_i,
    input  logic                     detect_valid_i,
    input  logic                     detect_ready_i,
    input  logic                     detect_faulty_i,
    input  logic [ID_SIZE-1:0]       detect_id_i,
    input  logic                     clear_i,
    output logic                     enable_o,
    output logic                     stall_o,
    output logic                     busy_o,
    output logic [ID_SIZE:0]         inflight_o,
    output logic [FaultCntWidth-1:0] fault_cnt_o,
    output logic                     exhausted_o,
    output logic [ID_SIZE-1:0]       exhausted_id_o,
    output logic                     drain_timeout_o,
    output logic                     overflow_o
);

    localparam int IfW  = ID_SIZE + 1;
    localparam int TmoW = $clog2(DrainTimeout + 1);
    localparam logic [IfW-1:0]  InflightMax = {1'b1, {ID_SIZE{1'b0}}};
    localparam logic [TmoW-1:0] TmoLast     = TmoW'(DrainTimeout - 1);

    ctrl_state_e state_reg, state_next;

    logic                     enable_reg, enable_next;
    logic                     stall_reg, stall_next;
    logic                     busy_reg, busy_next;
    logic [IfW-1:0]           inflight_reg, inflight_next;
    logic [TmoW-1:0]          tmo_reg, tmo_next;
    logic [FaultCntWidth-1:0] fault_cnt_reg, fault_cnt_next;
    logic                     drain_timeout_reg, drain_timeout_next;
    logic                     overflow_reg, overflow_next;

    logic issue, complete, detect, pending;
    logic drained, tmo_hit, ovf_event, track_en;

    assign issue    = issue_valid_i & issue_ready_i & ~stall_reg;
    assign complete = complete_valid_i & complete_ready_i;
    assign detect   = detect_valid_i & detect_ready_i;
    assign pending  = issue_valid_i & ~issue_ready_i;
    assign track_en = detect & enable_reg;

    always_comb begin
        inflight_next = inflight_reg;
        ovf_event     = 1'b0;
        if (issue && !complete) begin
            if (inflight_reg == InflightMax) begin
                ovf_event = 1'b1;
            end else begin
                inflight_next = inflight_reg + IfW'(1);
            end
        end else if (complete && !issue && (inflight_reg != '0)) begin
            inflight_next = inflight_reg - IfW'(1);
        end
    end

    // Uses the post-event count so a completion in this cycle can end the drain.
    assign drained = (inflight_next == '0);
    assign tmo_hit = (tmo_reg == TmoLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= STEADY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STEADY: begin
                if ((enable_req_i != enable_reg) && !pending) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drained || tmo_hit) begin
                    state_next = SWITCH;
                end else if (enable_req_i == enable_reg) begin
                    state_next = STEADY;
                end
            end
            SWITCH:  state_next = STEADY;
            default: state_next = STEADY;
        endcase
    end

    always_comb begin
        stall_next  = (state_next != STEADY);
        busy_next   = (state_next == DRAIN);
        enable_next = (state_reg == SWITCH) ? ~enable_reg : enable_reg;
        tmo_next    = '0;
        if ((state_reg == DRAIN) && (state_next == DRAIN)) begin
            tmo_next = tmo_reg + TmoW'(1);
        end
    end

    // Counters and sticky flags; clear_i beats any same-cycle set.
    always_comb begin
        fault_cnt_next = fault_cnt_reg;
        if (clear_i) begin
            fault_cnt_next = '0;
        end else if (track_en && detect_faulty_i && (fault_cnt_reg != '1)) begin
            fault_cnt_next = fault_cnt_reg + FaultCntWidth'(1);
        end
        drain_timeout_next = clear_i ? 1'b0 :
            (drain_timeout_reg | ((state_reg == DRAIN) && !drained && tmo_hit));
        overflow_next = clear_i ? 1'b0 : (overflow_reg | ovf_event);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_reg        <= EnableDefault;
            stall_reg         <= 1'b0;
            busy_reg          <= 1'b0;
            inflight_reg      <= '0;
            tmo_reg           <= '0;
            fault_cnt_reg     <= '0;
            drain_timeout_reg <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            enable_reg        <= enable_next;
            stall_reg         <= stall_next;
            busy_reg          <= busy_next;
            inflight_reg      <= inflight_next;
            tmo_reg           <= tmo_next;
            fault_cnt_reg     <= fault_cnt_next;
            drain_timeout_reg <= drain_timeout_next;
            overflow_reg      <= overflow_next;
        end
    end

    retry_budget_tracker #(
        .ID_SIZE    (ID_SIZE),
        .MaxRetries (MaxRetries)
    ) u_retry_budget_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .track_en     (track_en),
        .faulty       (detect_faulty_i),
        .id           (detect_id_i),
        .clear        (clear_i | (state_reg == SWITCH)),
        .exhausted    (exhausted_o),
        .exhausted_id (exhausted_id_o)
    );

    assign enable_o        = enable_reg;
    assign stall_o         = stall_reg;
    assign busy_o          = busy_reg;
    assign inflight_o      = inflight_reg;
    assign fault_cnt_o     = fault_cnt_reg;
    assign drain_timeout_o = drain_timeout_reg;
    assign overflow_o      = overflow_reg;

endmodule

// File: tb/tb_time_dmr_mode_ctrl.sv
// Scenario bench for time_dmr_mode_ctrl: directed mode-switch scenarios plus a
// randomized health-tracking run against an event-level model.
module tb_time_dmr_mode_ctrl;

    localparam int IdSize     = 4;
    localparam int MaxRetries = 3;
    localparam int NumIds     = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_req_i = 1'b0;
    logic        issue_valid_i = 1'b0, issue_ready_i = 1'b0;
    logic        complete_valid_i = 1'b0, complete_ready_i = 1'b0;
    logic        detect_valid_i = 1'b0, detect_ready_i = 1'b0, detect_faulty_i = 1'b0;
    logic [3:0]  detect_id_i = '0;
    logic        clear_i = 1'b0;
    logic        enable_o, stall_o, busy_o;
    logic [4:0]  inflight_o;
    logic [15:0] fault_cnt_o;
    logic        exhausted_o;
    logic [3:0]  exhausted_id_o;
    logic        drain_timeout_o, overflow_o;

    int errors = 0;
    int checks = 0;

    // Event-level reference state
    int m_inflight = 0;
    bit m_en = 1'b0;
    int m_fault = 0;
    int m_exh_id = 0;
    bit m_ovf = 1'b0;
    int m_retry [NumIds];

    always #5 clk_i = ~clk_i;

    time_dmr_mode_ctrl #(
        .ID_SIZE       (IdSize),
        .MaxRetries    (MaxRetries),
        .DrainTimeout  (8),
        .FaultCntWidth (16),
        .EnableDefault (1'b0)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .enable_req_i     (enable_req_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_i    (issue_ready_i),
        .complete_valid_i (complete_valid_i),
        .complete_ready_i (complete_ready_i),
        .detect_valid_i   (detect_valid_i),
        .detect_ready_i   (detect_ready_i),
        .detect_faulty_i  (detect_faulty_i),
        .detect_id_i      (detect_id_i),
        .clear_i          (clear_i),
        .enable_o         (enable_o),
        .stall_o          (stall_o),
        .busy_o           (busy_o),
        .inflight_o       (inflight_o),
        .fault_cnt_o      (fault_cnt_o),
        .exhausted_o      (exhausted_o),
        .exhausted_id_o   (exhausted_id_o),
        .drain_timeout_o  (drain_timeout_o),
        .overflow_o       (overflow_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        detect_valid_i = 1'b0; detect_ready_i = 1'b0; detect_faulty_i = 1'b0;
        detect_id_i = '0; clear_i = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        enable_req_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) step();
        checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0b want 0", enable_o); end
        checks++; if ({stall_o, busy_o, exhausted_o} !== 3'b000) begin errors++; $display("FAIL reset_stall_busy_exh: got %03b want 000", {stall_o, busy_o, exhausted_o}); end
        checks++; if ({drain_timeout_o, overflow_o} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %02b want 00", {drain_timeout_o, overflow_o}); end
        rst_ni = 1'b1;
        step();
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight_o); end
        checks++; if (fault_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt_o); end
        checks++; if (exhausted_id_o !== 4'd0) begin errors++; $display("FAIL reset_exh_id: got %0d want 0", exhausted_id_o); end
        $display("reset done");
    endtask

    task automatic test_idle_enable();
        enable_req_i = 1'b1;
        step();
        checks++; if ({stall_o, busy_o, enable_o} !== 3'b110) begin errors++; $display("FAIL idle_drain: stall/busy/en got %03b want 110", {stall_o, busy_o, enable_o}); end
        step();
        checks++; if ({stall_o, enable_o} !== 2'b10) begin errors++; $display("FAIL idle_switch: stall/en got %02b want 10", {stall_o, enable_o}); end
        step();
        checks++; if ({stall_o, enable_o} !== 2'b01) begin errors++; $display("FAIL idle_steady: stall/en got %02b want 01", {stall_o, enable_o}); end
        step();
        checks++; if ({stall_o, busy_o, enable_o} !== 3'b001) begin errors++; $display("FAIL idle_hold: stall/busy/en got %03b want 001", {stall_o, busy_o, enable_o}); end
        m_en = 1'b1;
        $display("idle enable: enable_o=%0b", enable_o);
    endtask

    task automatic test_drain_wait();
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (inflight_o !== 5'(k)) begin errors++; $display("FAIL drain_issue: inflight got %0d want %0d", inflight_o, k); end
        end
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        enable_req_i = 1'b0;
        step();
        checks++; if ({stall_o, busy_o, enable_o} !== 3'b111) begin errors++; $display("FAIL drain_enter: stall/busy/en got %03b want 111", {stall_o, busy_o, enable_o}); end
        // Issue attempts while stalled must not be counted
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        step();
        checks++; if (inflight_o !== 5'd3) begin errors++; $display("FAIL drain_stalled_issue: inflight got %0d want 3", inflight_o); end
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            step();
            checks++; if (inflight_o !== 5'(k)) begin errors++; $display("FAIL drain_complete: inflight got %0d want %0d", inflight_o, k); end
            checks++; if ({stall_o, enable_o} !== 2'b11) begin errors++; $display("FAIL drain_hold: stall/en got %02b want 11", {stall_o, enable_o}); end
        end
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        step();
        checks++; if ({stall_o, enable_o} !== 2'b00) begin errors++; $display("FAIL drain_done: stall/en got %02b want 00", {stall_o, enable_o}); end
        m_en = 1'b0;
        $display("drain wait: enable_o=%0b inflight=%0d", enable_o, inflight_o);
    endtask

    task automatic test_timeout();
        // Detections are ignored while redundancy is off
        detect_valid_i = 1'b1; detect_ready_i = 1'b1; detect_faulty_i = 1'b1; detect_id_i = 4'd5;
        step();
        detect_valid_i = 1'b0; detect_ready_i = 1'b0; detect_faulty_i = 1'b0;
        checks++; if (fault_cnt_o !== 16'(m_fault)) begin errors++; $display("FAIL disabled_detect: fault_cnt got %0d want %0d", fault_cnt_o, m_fault); end
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        step();
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        enable_req_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if ({stall_o, busy_o, enable_o, drain_timeout_o} !== 4'b1100) begin errors++; $display("FAIL tmo_drain%0d: stall/busy/en/tmo got %04b want 1100", k, {stall_o, busy_o, enable_o, drain_timeout_o}); end
        end
        step();
        checks++; if ({stall_o, busy_o, enable_o, drain_timeout_o} !== 4'b1001) begin errors++; $display("FAIL tmo_switch: stall/busy/en/tmo got %04b want 1001", {stall_o, busy_o, enable_o, drain_timeout_o}); end
        step();
        checks++; if ({stall_o, enable_o, drain_timeout_o} !== 3'b011) begin errors++; $display("FAIL tmo_steady: stall/en/tmo got %03b want 011", {stall_o, enable_o, drain_timeout_o}); end
        repeat (3) step();
        checks++; if (drain_timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b want 1", drain_timeout_o); end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++; if (drain_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %0b want 0", drain_timeout_o); end
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        step();
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL tmo_flush: inflight got %0d want 0", inflight_o); end
        m_en = 1'b1;
        $display("timeout: enable_o=%0b", enable_o);
    endtask

    task automatic test_pending_defer();
        issue_valid_i = 1'b1; issue_ready_i = 1'b0;
        enable_req_i = 1'b0;
        repeat (2) begin
            step();
            checks++; if ({stall_o, inflight_o} !== {1'b0, 5'd0}) begin errors++; $display("FAIL defer_wait: stall got %0b inflight %0d want 0/0", stall_o, inflight_o); end
        end
        issue_ready_i = 1'b1;
        step();
        checks++; if ({stall_o, inflight_o} !== {1'b1, 5'd1}) begin errors++; $display("FAIL defer_enter: stall got %0b inflight %0d want 1/1", stall_o, inflight_o); end
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        step();
        checks++; if ({stall_o, enable_o, inflight_o} !== {2'b11, 5'd0}) begin errors++; $display("FAIL defer_switch: stall/en got %02b inflight %0d want 11/0", {stall_o, enable_o}, inflight_o); end
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        step();
        checks++; if ({stall_o, enable_o} !== 2'b00) begin errors++; $display("FAIL defer_done: stall/en got %02b want 00", {stall_o, enable_o}); end
        m_en = 1'b0;
        $display("pending defer: enable_o=%0b", enable_o);
    endtask

    task automatic test_abort();
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        repeat (2) step();
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        enable_req_i = 1'b1;
        repeat (2) step();
        checks++; if ({stall_o, busy_o} !== 2'b11) begin errors++; $display("FAIL abort_drain: stall/busy got %02b want 11", {stall_o, busy_o}); end
        enable_req_i = 1'b0;
        step();
        checks++; if ({stall_o, busy_o, enable_o} !== 3'b000) begin errors++; $display("FAIL abort_exit: stall/busy/en got %03b want 000", {stall_o, busy_o, enable_o}); end
        step();
        checks++; if ({stall_o, enable_o, inflight_o} !== {2'b00, 5'd2}) begin errors++; $display("FAIL abort_hold: stall/en got %02b inflight %0d want 00/2", {stall_o, enable_o}, inflight_o); end
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        repeat (2) step();
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        $display("abort: enable_o=%0b inflight=%0d", enable_o, inflight_o);
    endtask

    task automatic test_same_cycle();
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        step();
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        enable_req_i = 1'b1;
        step();
        // Request withdrawn together with the last completion: completion wins
        enable_req_i = 1'b0;
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        step();
        checks++; if ({stall_o, enable_o, inflight_o} !== {2'b10, 5'd0}) begin errors++; $display("FAIL same_switch: stall/en got %02b inflight %0d want 10/0", {stall_o, enable_o}, inflight_o); end
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        enable_req_i = 1'b1;
        step();
        checks++; if ({stall_o, enable_o} !== 2'b01) begin errors++; $display("FAIL same_done: stall/en got %02b want 01", {stall_o, enable_o}); end
        m_en = 1'b1;
        $display("same cycle: enable_o=%0b", enable_o);
    endtask

    task automatic test_exhaustion();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        m_fault = 0;
        detect_valid_i = 1'b1; detect_ready_i = 1'b1; detect_faulty_i = 1'b1; detect_id_i = 4'd5;
        for (int k = 1; k <= 3; k++) begin
            step();
            m_fault++;
            checks++; if (fault_cnt_o !== 16'(m_fault)) begin errors++; $display("FAIL exh_fault_cnt: got %0d want %0d", fault_cnt_o, m_fault); end
            checks++; if (exhausted_o !== (k == 3)) begin errors++; $display("FAIL exh_pulse%0d: got %0b want %0b", k, exhausted_o, (k == 3)); end
        end
        checks++; if (exhausted_id_o !== 4'd5) begin errors++; $display("FAIL exh_id: got %0d want 5", exhausted_id_o); end
        m_exh_id = 5;
        detect_valid_i = 1'b0;
        step();
        checks++; if ({exhausted_o, exhausted_id_o} !== {1'b0, 4'd5}) begin errors++; $display("FAIL exh_after: pulse %0b id %0d want 0/5", exhausted_o, exhausted_id_o); end
        detect_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            detect_faulty_i = (k != 1);
            step();
            if (k != 1) m_fault++;
            checks++; if (exhausted_o !== 1'b0) begin errors++; $display("FAIL exh_broken%0d: pulse got %0b want 0", k, exhausted_o); end
        end
        checks++; if (fault_cnt_o !== 16'(m_fault)) begin errors++; $display("FAIL exh_total: fault_cnt got %0d want %0d", fault_cnt_o, m_fault); end
        detect_faulty_i = 1'b0;
        step();
        set_idle();
        $display("exhaustion: fault_cnt=%0d exhausted_id=%0d", fault_cnt_o, exhausted_id_o);
    endtask

    task automatic test_simultaneous();
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        repeat (2) step();
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        step();
        checks++; if (inflight_o !== 5'd2) begin errors++; $display("FAIL simul_same: inflight got %0d want 2", inflight_o); end
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        repeat (14) step();
        checks++; if ({overflow_o, inflight_o} !== {1'b0, 5'd16}) begin errors++; $display("FAIL simul_full: ovf %0b inflight %0d want 0/16", overflow_o, inflight_o); end
        step();
        checks++; if ({overflow_o, inflight_o} !== {1'b1, 5'd16}) begin errors++; $display("FAIL simul_overflow: ovf %0b inflight %0d want 1/16", overflow_o, inflight_o); end
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++; if ({overflow_o, inflight_o} !== {1'b0, 5'd16}) begin errors++; $display("FAIL simul_clear: ovf %0b inflight %0d want 0/16", overflow_o, inflight_o); end
        complete_valid_i = 1'b1; complete_ready_i = 1'b1;
        repeat (17) step();
        complete_valid_i = 1'b0; complete_ready_i = 1'b0;
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL simul_underflow: inflight got %0d want 0", inflight_o); end
        m_inflight = 0; m_ovf = 1'b0; m_fault = 0;
        $display("simultaneous: inflight=%0d", inflight_o);
    endtask

    task automatic test_random();
        bit iss, cmp, det, e_exh;
        int id;
        set_idle();
        enable_req_i = m_en;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        m_fault = 0; m_ovf = 1'b0;
        foreach (m_retry[i]) m_retry[i] = 0;
        for (int n = 0; n < 300; n++) begin
            issue_valid_i    = ($urandom_range(0, 2) == 0);
            issue_ready_i    = $urandom_range(0, 1);
            complete_valid_i = ($urandom_range(0, 2) == 0);
            complete_ready_i = $urandom_range(0, 1);
            detect_valid_i   = $urandom_range(0, 1);
            detect_ready_i   = ($urandom_range(0, 3) != 0);
            detect_faulty_i  = ($urandom_range(0, 2) != 0);
            id               = $urandom_range(0, 3);
            detect_id_i      = 4'(id);
            clear_i          = ($urandom_range(0, 24) == 0);
            iss = issue_valid_i && issue_ready_i;
            cmp = complete_valid_i && complete_ready_i;
            det = detect_valid_i && detect_ready_i;
            e_exh = 1'b0;
            if (iss && !cmp) begin
                if (m_inflight == NumIds) m_ovf = 1'b1;
                else m_inflight++;
            end else if (cmp && !iss && m_inflight > 0) begin
                m_inflight--;
            end
            if (clear_i) begin
                m_ovf = 1'b0; m_fault = 0;
                foreach (m_retry[i]) m_retry[i] = 0;
            end else if (det && detect_faulty_i) begin
                if (m_fault < 65535) m_fault++;
                m_retry[id]++;
                if (m_retry[id] == MaxRetries) begin
                    e_exh = 1'b1; m_exh_id = id; m_retry[id] = 0;
                end
            end else if (det) begin
                m_retry[id] = 0;
            end
            $display("txn %0d: issue=%0b complete=%0b detect=%0b faulty=%0b id=%0d clear=%0b", n, iss, cmp, det, detect_faulty_i, id, clear_i);
            step();
            checks++; if (inflight_o !== 5'(m_inflight)) begin errors++; $display("FAIL rnd_inflight@%0d: got %0d want %0d", n, inflight_o, m_inflight); end
            checks++; if (fault_cnt_o !== 16'(m_fault)) begin errors++; $display("FAIL rnd_fault@%0d: got %0d want %0d", n, fault_cnt_o, m_fault); end
            checks++; if (exhausted_o !== e_exh) begin errors++; $display("FAIL rnd_exh@%0d: got %0b want %0b", n, exhausted_o, e_exh); end
            checks++; if (exhausted_id_o !== 4'(m_exh_id)) begin errors++; $display("FAIL rnd_exh_id@%0d: got %0d want %0d", n, exhausted_id_o, m_exh_id); end
            checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, overflow_o, m_ovf); end
            checks++; if ({stall_o, enable_o} !== {1'b0, m_en}) begin errors++; $display("FAIL rnd_mode@%0d: stall/en got %02b want 0%0b", n, {stall_o, enable_o}, m_en); end
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        issue_valid_i = 1'b1; issue_ready_i = 1'b1;
        step();
        issue_valid_i = 1'b0; issue_ready_i = 1'b0;
        enable_req_i = 1'b0;
        step();
        checks++; if ({stall_o, enable_o} !== 2'b11) begin errors++; $display("FAIL arst_drain: stall/en got %02b want 11", {stall_o, enable_o}); end
        #3 rst_ni = 1'b0;
        #1;
        checks++; if ({enable_o, stall_o, busy_o} !== 3'b000) begin errors++; $display("FAIL arst_async: en/stall/busy got %03b want 000", {enable_o, stall_o, busy_o}); end
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL arst_inflight: got %0d want 0", inflight_o); end
        step();
        rst_ni = 1'b1;
        step();
        checks++; if ({enable_o, stall_o} !== 2'b00) begin errors++; $display("FAIL arst_after: en/stall got %02b want 00", {enable_o, stall_o}); end
        m_en = 1'b0; m_inflight = 0;
        $display("async reset: enable_o=%0b", enable_o);
    endtask

    initial begin
        test_reset();
        test_idle_enable();
        test_drain_wait();
        test_timeout();
        test_pending_defer();
        test_abort();
        test_same_cycle();
        test_exhaustion();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
